// File: rtl/intr_srvc_seq.sv
// Interrupt service sequencer: latches the controller's winning ID, runs the CPU irq/ack/eoi
// handshake, pulses serviced back to the controller and counts completions. Optional macro: INTR_TIMEOUT_EN.
module intr_srvc_seq #(
    parameter int INTRPT_WIDTH   = 4,
    parameter int CNT_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    pclk_i,
    input  logic                    prst_i,
    input  logic [INTRPT_WIDTH-1:0] intr_to_srvc_i,
    input  logic                    intr_valid_i,
    output logic                    intr_srvcd_o,
    output logic                    cpu_irq_o,
    output logic [INTRPT_WIDTH-1:0] cpu_irq_id_o,
    input  logic                    cpu_ack_i,
    input  logic                    cpu_eoi_i,
    output logic                    busy_o,
    output logic [CNT_WIDTH-1:0]    srvc_cnt_o,
    output logic                    timeout_o
);

    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_REQ     = 5'b00010,
        ST_SERVICE = 5'b00100,
        ST_DONE    = 5'b01000,
        ST_RELEASE = 5'b10000
    } state_t;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t                  state_q, state_d, nxt_s;
    logic                    srvcd_q, srvcd_d;
    logic                    irq_q, irq_d;
    logic [INTRPT_WIDTH-1:0] id_q, id_d;
    logic                    busy_q, busy_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    expire_s;

    // Natural next state from the handshake inputs, before any timeout override
    always_comb begin
        nxt_s = state_q;
        case (state_q)
            ST_IDLE: begin
                if (intr_valid_i) nxt_s = ST_REQ;
                else              nxt_s = ST_IDLE;
            end
            ST_REQ: begin
                if (!intr_valid_i)             nxt_s = ST_IDLE;
                else if (cpu_ack_i && cpu_eoi_i) nxt_s = ST_DONE;
                else if (cpu_ack_i)            nxt_s = ST_SERVICE;
                else                           nxt_s = ST_REQ;
            end
            ST_SERVICE: begin
                if (cpu_eoi_i) nxt_s = ST_DONE;
                else           nxt_s = ST_SERVICE;
            end
            ST_DONE: nxt_s = ST_RELEASE;
            ST_RELEASE: begin
                if (!intr_valid_i) nxt_s = ST_IDLE;
                else               nxt_s = ST_RELEASE;
            end
            default: nxt_s = ST_IDLE;
        endcase
    end

`ifdef INTR_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             tmo_q;
    logic             waiting_s;

    // Expiry only forces DONE when the handshake itself would not move the FSM this cycle
    always_comb begin
        waiting_s = (state_q == ST_REQ) || (state_q == ST_SERVICE);
        expire_s  = 1'b0;
        if (waiting_s && (nxt_s == state_q) && (tmr_q == TMR_LAST)) expire_s = 1'b1;
        else                                                       expire_s = 1'b0;
        state_d = expire_s ? ST_DONE : nxt_s;
        if (waiting_s && (state_d == state_q)) tmr_d = tmr_q + {{(TMR_W-1){1'b0}}, 1'b1};
        else                                   tmr_d = {TMR_W{1'b0}};
    end

    // Wait timer and registered timeout pulse
    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            tmr_q <= {TMR_W{1'b0}};
            tmo_q <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            tmo_q <= expire_s;
        end
    end

    assign timeout_o = tmo_q;
`else
    // Without the timer the handshake alone decides the next state
    always_comb begin
        expire_s = 1'b0;
        state_d  = nxt_s;
    end

    assign timeout_o = 1'b0;
`endif

    // Registered outputs are derived from the next state so they line up with the state register
    always_comb begin
        irq_d   = (state_d == ST_REQ);
        busy_d  = (state_d != ST_IDLE);
        srvcd_d = (state_d == ST_DONE);
        id_d    = id_q;
        cnt_d   = cnt_q;
        if ((state_q == ST_IDLE) && (state_d == ST_REQ)) id_d = intr_to_srvc_i;
        else                                            id_d = id_q;
        if (srvcd_d && !expire_s && (cnt_q != {CNT_WIDTH{1'b1}}))
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        else
            cnt_d = cnt_q;
    end

    // State and output registers
    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            state_q <= ST_IDLE;
            srvcd_q <= 1'b0;
            irq_q   <= 1'b0;
            id_q    <= {INTRPT_WIDTH{1'b0}};
            busy_q  <= 1'b0;
            cnt_q   <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            srvcd_q <= srvcd_d;
            irq_q   <= irq_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign intr_srvcd_o = srvcd_q;
    assign cpu_irq_o    = irq_q;
    assign cpu_irq_id_o = id_q;
    assign busy_o       = busy_q;
    assign srvc_cnt_o   = cnt_q;

endmodule

// File: tb/tb_intr_srvc_seq.sv
// Directed self-checking bench for intr_srvc_seq; the timeout scenario runs when INTR_TIMEOUT_EN is defined.
module tb_intr_srvc_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] id_in = 4'h0;
    logic       valid = 1'b0;
    logic       ack = 1'b0;
    logic       eoi = 1'b0;
    logic       srvcd, irq, busy, tmo;
    logic [3:0] id_out;
    logic [7:0] cnt;
    logic [3:0] flags;
    int         total = 0;
    int         bad = 0;

    intr_srvc_seq #(.INTRPT_WIDTH(4), .CNT_WIDTH(8), .TIMEOUT_CYCLES(8)) dut (
        .pclk_i(clk), .prst_i(rst),
        .intr_to_srvc_i(id_in), .intr_valid_i(valid),
        .intr_srvcd_o(srvcd), .cpu_irq_o(irq), .cpu_irq_id_o(id_out),
        .cpu_ack_i(ack), .cpu_eoi_i(eoi),
        .busy_o(busy), .srvc_cnt_o(cnt), .timeout_o(tmo)
    );

    always #5 clk = ~clk;

    // flags = {irq, busy, srvcd, timeout}
    assign flags = {irq, busy, srvcd, tmo};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        total++;
        if (flags !== 4'b0000 || id_out !== 4'h0 || cnt !== 8'h00) begin
            bad++; $display("FAIL reset flags=%b id=%h cnt=%0d expected 0000/0/0", flags, id_out, cnt);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        valid = 1'b1; id_in = 4'hA; tick();
        total++;
        if (flags !== 4'b1100 || id_out !== 4'hA) begin
            bad++; $display("FAIL basic_req flags=%b id=%h expected 1100/a", flags, id_out);
        end
        ack = 1'b1; tick(); ack = 1'b0;
        total++;
        if (flags !== 4'b0100 || cnt !== 8'd0) begin
            bad++; $display("FAIL basic_service flags=%b cnt=%0d expected 0100/0", flags, cnt);
        end
        eoi = 1'b1; tick(); eoi = 1'b0;
        total++;
        if (flags !== 4'b0110 || cnt !== 8'd1) begin
            bad++; $display("FAIL basic_done flags=%b cnt=%0d expected 0110/1", flags, cnt);
        end
        tick();
        total++;
        if (flags !== 4'b0100 || cnt !== 8'd1 || id_out !== 4'hA) begin
            bad++; $display("FAIL basic_release flags=%b cnt=%0d id=%h expected 0100/1/a", flags, cnt, id_out);
        end
        valid = 1'b0; tick();
        total++;
        if (flags !== 4'b0000 || id_out !== 4'hA) begin
            bad++; $display("FAIL basic_idle flags=%b id=%h expected 0000/a", flags, id_out);
        end
    endtask

    task automatic test_ack_eoi_together();
        valid = 1'b1; id_in = 4'h3; tick();
        ack = 1'b1; eoi = 1'b1; tick(); ack = 1'b0; eoi = 1'b0;
        total++;
        if (flags !== 4'b0110 || cnt !== 8'd2 || id_out !== 4'h3) begin
            bad++; $display("FAIL fast_done flags=%b cnt=%0d id=%h expected 0110/2/3", flags, cnt, id_out);
        end
        valid = 1'b0; tick(); tick();
        total++;
        if (flags !== 4'b0000 || cnt !== 8'd2) begin
            bad++; $display("FAIL fast_idle flags=%b cnt=%0d expected 0000/2", flags, cnt);
        end
    endtask

    task automatic test_withdraw();
        valid = 1'b1; id_in = 4'h7; tick();
        eoi = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (flags !== 4'b1100) begin
                bad++; $display("FAIL eoi_ignored cyc=%0d flags=%b expected 1100", i, flags);
            end
        end
        eoi = 1'b0; valid = 1'b0; tick();
        total++;
        if (flags !== 4'b0000 || cnt !== 8'd2) begin
            bad++; $display("FAIL withdraw flags=%b cnt=%0d expected 0000/2", flags, cnt);
        end
    endtask

    task automatic test_back_to_back();
        valid = 1'b1; id_in = 4'h1; tick();
        ack = 1'b1; eoi = 1'b1; tick(); ack = 1'b0; eoi = 1'b0;
        id_in = 4'h5;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (flags !== 4'b0100 || id_out !== 4'h1) begin
                bad++; $display("FAIL stale_hold cyc=%0d flags=%b id=%h expected 0100/1", i, flags, id_out);
            end
        end
        valid = 1'b0; tick();
        total++;
        if (flags !== 4'b0000) begin
            bad++; $display("FAIL b2b_idle flags=%b expected 0000", flags);
        end
        valid = 1'b1; tick();
        total++;
        if (flags !== 4'b1100 || id_out !== 4'h5 || cnt !== 8'd3) begin
            bad++; $display("FAIL b2b_capture flags=%b id=%h cnt=%0d expected 1100/5/3", flags, id_out, cnt);
        end
        ack = 1'b1; eoi = 1'b1; tick(); ack = 1'b0; eoi = 1'b0;
        valid = 1'b0; tick(); tick();
    endtask

`ifdef INTR_TIMEOUT_EN
    task automatic test_timeout();
        valid = 1'b1; id_in = 4'h2; tick();
        for (int i = 1; i < 8; i++) begin
            tick();
            total++;
            if (flags !== 4'b1100) begin
                bad++; $display("FAIL tmo_wait cyc=%0d flags=%b expected 1100", i, flags);
            end
        end
        tick();
        total++;
        if (flags !== 4'b0111 || cnt !== 8'd4) begin
            bad++; $display("FAIL tmo_fire flags=%b cnt=%0d expected 0111/4", flags, cnt);
        end
        valid = 1'b0; tick();
        total++;
        if (flags !== 4'b0100) begin
            bad++; $display("FAIL tmo_release flags=%b expected 0100", flags);
        end
        tick();
        valid = 1'b1; tick();
        for (int i = 1; i < 8; i++) tick();
        ack = 1'b1; tick(); ack = 1'b0;
        total++;
        if (flags !== 4'b0100) begin
            bad++; $display("FAIL tmo_ack_wins flags=%b expected 0100", flags);
        end
        eoi = 1'b1; tick(); eoi = 1'b0;
        total++;
        if (flags !== 4'b0110 || cnt !== 8'd5) begin
            bad++; $display("FAIL tmo_after_ack flags=%b cnt=%0d expected 0110/5", flags, cnt);
        end
        valid = 1'b0; tick(); tick();
    endtask
`else
    task automatic test_no_timeout();
        valid = 1'b1; id_in = 4'h2; tick();
        for (int i = 0; i < 20; i++) tick();
        total++;
        if (flags !== 4'b1100 || cnt !== 8'd4) begin
            bad++; $display("FAIL no_timeout flags=%b cnt=%0d expected 1100/4", flags, cnt);
        end
        valid = 1'b0; tick();
    endtask
`endif

    task automatic test_async_reset();
        valid = 1'b1; id_in = 4'h9; tick();
        ack = 1'b1; tick(); ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if (flags !== 4'b0000 || id_out !== 4'h0 || cnt !== 8'd0) begin
            bad++; $display("FAIL async_reset flags=%b id=%h cnt=%0d expected 0000/0/0", flags, id_out, cnt);
        end
        eoi = 1'b1; tick(); eoi = 1'b0; valid = 1'b0;
        rst = 1'b0; tick();
        total++;
        if (flags !== 4'b0000 || cnt !== 8'd0) begin
            bad++; $display("FAIL post_reset flags=%b cnt=%0d expected 0000/0", flags, cnt);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] exp_cnt;
        for (int i = 0; i < 256; i++) begin
            valid = 1'b1; id_in = 4'(i); tick();
            ack = 1'b1; eoi = 1'b1; tick(); ack = 1'b0; eoi = 1'b0;
            exp_cnt = (i >= 254) ? 8'hFF : 8'(i + 1);
            if (i >= 250 || i == 0) begin
                total++;
                if (cnt !== exp_cnt || srvcd !== 1'b1) begin
                    bad++; $display("FAIL saturate n=%0d cnt=%0d srvcd=%b expected %0d/1", i + 1, cnt, srvcd, exp_cnt);
                end
            end
            valid = 1'b0; tick(); tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ack_eoi_together();
        test_withdraw();
        test_back_to_back();
`ifdef INTR_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_async_reset();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
